// File: rtl/daq_pkg.sv
// Shared types and helpers for the multi-ADC acquisition packetizer.
package daq_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StConv,
    StWaitBh,
    StWaitBl,
    StHdrPre,
    StHdrSeq,
    StRdLo,
    StRdHi,
    StCsum
  } daq_state_t;

  localparam logic [15:0] DefaultPreamble = 16'hAAAA;
  localparam int unsigned CsumW = 16;
  localparam logic [4:0] NoAdc = 5'd16;

  // Lowest set mask bit at or above 'from'; NoAdc when there is none.
  function automatic logic [4:0] next_adc(input logic [15:0] mask, input logic [4:0] from);
    logic [4:0] idx;
    idx = NoAdc;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i] && (5'(i) >= from)) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/daq_period_trig.sv
// Free-running period counter producing a one-cycle acquisition trigger.
module daq_period_trig #(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                en_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                trig_o
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                run;

  always_comb begin
    run    = en_i && (period_i != '0);
    // >= so a period shortened at runtime still fires instead of wrapping
    trig_o = run && (cnt_q >= (period_i - PERIOD_W'(1)));
    cnt_d  = '0;
    if (run && !trig_o) cnt_d = cnt_q + PERIOD_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/daq_packetizer_gen.sv
// Acquisition sequencer for NUM_ADC shared-bus converters, framing each conversion
// as preamble, sequence, samples and checksum on a valid/ready word stream.
module daq_packetizer_gen
  import daq_pkg::*;
#(
  parameter int unsigned NUM_ADC      = 8,
  parameter int unsigned CH_PER_ADC   = 8,
  parameter int unsigned DW           = CsumW,
  parameter logic [DW-1:0] PREAMBLE   = DW'(DefaultPreamble),
  parameter int unsigned PERIOD_W     = 16,
  parameter int unsigned CONV_LOW_CYC = 4,
  parameter int unsigned RD_LOW_CYC   = 2,
  parameter int unsigned RD_HIGH_CYC  = 2,
  parameter int unsigned BUSY_TIMEOUT = 4096
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                en_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [NUM_ADC-1:0]  adc_mask_i,
  output logic                conv_o,
  input  logic                busy_i,
  output logic [NUM_ADC-1:0]  cs_o,
  output logic                rd_o,
  input  logic [DW-1:0]       db_i,
  output logic [DW-1:0]       pkt_data_o,
  output logic                pkt_valid_o,
  output logic                pkt_last_o,
  input  logic                pkt_ready_i,
  output logic [7:0]          overrun_cnt_o,
  output logic                timeout_err_o,
  output logic                active_o
);

  localparam int unsigned TW = $clog2(BUSY_TIMEOUT + CONV_LOW_CYC + RD_LOW_CYC + RD_HIGH_CYC + 1);

  daq_state_t         state_q, state_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic [4:0]         adc_q, adc_d;
  logic [15:0]        ch_q, ch_d;
  logic [NUM_ADC-1:0] mask_q, mask_d;
  logic [DW-1:0]      seq_q, seq_d, csum_q, csum_d, data_q, data_d;
  logic               valid_q, valid_d, last_q, last_d, tmo_q, tmo_d;
  logic [7:0]         ovr_q, ovr_d;
  logic               trig, out_free, last_ch, cs_sel;
  logic [15:0]        mask_ext;
  logic [4:0]         nxt_first, nxt_after;

  daq_period_trig #(
    .PERIOD_W (PERIOD_W)
  ) u_trig (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .en_i     (en_i),
    .period_i (period_i),
    .trig_o   (trig)
  );

  always_comb begin
    mask_ext              = '0;
    mask_ext[NUM_ADC-1:0] = mask_q;
    nxt_first             = next_adc(mask_ext, 5'd0);
    nxt_after             = next_adc(mask_ext, adc_q + 5'd1);
    // Output register is empty now or drains on this edge.
    out_free              = !valid_q || pkt_ready_i;
    last_ch               = (ch_q == 16'(CH_PER_ADC - 1));
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    adc_d   = adc_q;
    ch_d    = ch_q;
    mask_d  = mask_q;
    seq_d   = seq_q;
    csum_d  = csum_q;
    data_d  = data_q;
    valid_d = valid_q && !pkt_ready_i;
    last_d  = last_q;
    tmo_d   = tmo_q;
    ovr_d   = ovr_q;

    if (trig && (state_q != StIdle) && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;

    unique case (state_q)
      StIdle: begin
        if (trig) begin
          state_d = StConv;
          mask_d  = adc_mask_i;
          tmr_d   = '0;
        end
      end
      StConv: begin
        if (tmr_q == TW'(CONV_LOW_CYC - 1)) begin
          state_d = StWaitBh;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      StWaitBh: begin
        if (busy_i) begin
          state_d = StWaitBl;
          tmr_d   = '0;
        end else if (tmr_q == TW'(BUSY_TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      StWaitBl: begin
        // Register is always empty here: the previous packet left only on acceptance.
        if (!busy_i) begin
          state_d = StHdrPre;
          valid_d = 1'b1;
          data_d  = PREAMBLE;
          last_d  = 1'b0;
        end else if (tmr_q == TW'(BUSY_TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      StHdrPre: begin
        if (out_free) begin
          state_d = StHdrSeq;
          valid_d = 1'b1;
          data_d  = seq_q;
          csum_d  = seq_q;
        end
      end
      StHdrSeq: begin
        if (out_free) begin
          if (nxt_first != NoAdc) begin
            state_d = StRdLo;
            adc_d   = nxt_first;
            ch_d    = '0;
            tmr_d   = '0;
          end else begin
            state_d = StCsum;
            valid_d = 1'b1;
            data_d  = csum_q;
            last_d  = 1'b1;
          end
        end
      end
      StRdLo: begin
        if (tmr_q == TW'(RD_LOW_CYC - 1)) begin
          state_d = StRdHi;
          valid_d = 1'b1;
          data_d  = db_i;
          csum_d  = csum_q + db_i;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      StRdHi: begin
        if (tmr_q < TW'(RD_HIGH_CYC - 1)) begin
          tmr_d = tmr_q + TW'(1);
        end else if (out_free) begin
          tmr_d = '0;
          if (!last_ch) begin
            state_d = StRdLo;
            ch_d    = ch_q + 16'd1;
          end else if (nxt_after != NoAdc) begin
            state_d = StRdLo;
            adc_d   = nxt_after;
            ch_d    = '0;
          end else begin
            state_d = StCsum;
            valid_d = 1'b1;
            data_d  = csum_q;
            last_d  = 1'b1;
          end
        end
      end
      StCsum: begin
        if (valid_q && pkt_ready_i) begin
          state_d = StIdle;
          seq_d   = seq_q + DW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      adc_q   <= '0;
      ch_q    <= '0;
      mask_q  <= '0;
      seq_q   <= '0;
      csum_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      tmo_q   <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      adc_q   <= adc_d;
      ch_q    <= ch_d;
      mask_q  <= mask_d;
      seq_q   <= seq_d;
      csum_q  <= csum_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
    end
  end

  // Chip select drops during the final RD_HI of each ADC, leaving a gap between ADCs.
  always_comb begin
    cs_sel = (state_q == StRdLo) || ((state_q == StRdHi) && !last_ch);
    cs_o   = '1;
    for (int i = 0; i < NUM_ADC; i++) begin
      if (cs_sel && (adc_q == 5'(i))) cs_o[i] = 1'b0;
    end
  end

  assign conv_o        = (state_q != StConv);
  assign rd_o          = (state_q != StRdLo);
  assign pkt_data_o    = data_q;
  assign pkt_valid_o   = valid_q;
  assign pkt_last_o    = last_q;
  assign overrun_cnt_o = ovr_q;
  assign timeout_err_o = tmo_q;
  assign active_o      = (state_q != StIdle);

endmodule

// File: tb/tb_daq_packetizer_gen.sv
// Directed bench for daq_packetizer_gen with a two-ADC bus model and a word collector.
module tb_daq_packetizer_gen;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        en_i;
  logic [15:0] period_i;
  logic [1:0]  adc_mask_i;
  logic        conv_o;
  logic        busy_i = 1'b0;
  logic [1:0]  cs_o;
  logic        rd_o;
  logic [15:0] db_i;
  logic [15:0] pkt_data_o;
  logic        pkt_valid_o;
  logic        pkt_last_o;
  logic        pkt_ready_i = 1'b1;
  logic [7:0]  overrun_cnt_o;
  logic        timeout_err_o;
  logic        active_o;

  always #5 clk = ~clk;

  daq_packetizer_gen #(
    .NUM_ADC    (2),
    .CH_PER_ADC (2)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .en_i          (en_i),
    .period_i      (period_i),
    .adc_mask_i    (adc_mask_i),
    .conv_o        (conv_o),
    .busy_i        (busy_i),
    .cs_o          (cs_o),
    .rd_o          (rd_o),
    .db_i          (db_i),
    .pkt_data_o    (pkt_data_o),
    .pkt_valid_o   (pkt_valid_o),
    .pkt_last_o    (pkt_last_o),
    .pkt_ready_i   (pkt_ready_i),
    .overrun_cnt_o (overrun_cnt_o),
    .timeout_err_o (timeout_err_o),
    .active_o      (active_o)
  );

  // Bench controls
  logic [15:0] base = 16'h0;
  logic        busy_en = 1'b1;
  logic        ready_mode = 1'b0;
  logic        ready_lvl = 1'b1;
  int          tgl = 0;

  always @(negedge clk) begin
    if (ready_mode) begin
      if (tgl == 2) begin
        pkt_ready_i <= ~pkt_ready_i;
        tgl <= 0;
      end else begin
        tgl <= tgl + 1;
      end
    end else begin
      pkt_ready_i <= ready_lvl;
    end
  end

  // ADC model: sample = base + adc*2 + channel + 1
  int   ch_cnt [2];
  int   sel_now, sel_q, bcnt;
  logic rd_prev = 1'b1;
  logic conv_prev = 1'b1;

  initial begin
    ch_cnt[0] = 0;
    ch_cnt[1] = 0;
    sel_q = 0;
    bcnt = 0;
  end

  always_comb begin
    sel_now = (cs_o[1] == 1'b0) ? 1 : 0;
    db_i    = base + 16'(sel_now * 2 + ch_cnt[sel_now] + 1);
  end

  always @(posedge clk) begin
    conv_prev <= conv_o;
    rd_prev   <= rd_o;
    if (!rd_o) sel_q <= sel_now;
    if (conv_prev && !conv_o) begin
      ch_cnt[0] <= 0;
      ch_cnt[1] <= 0;
    end else if (!rd_prev && rd_o) begin
      ch_cnt[sel_q] <= ch_cnt[sel_q] + 1;
    end
    if (conv_prev && !conv_o && busy_en) bcnt <= 1;
    else if (bcnt != 0 && bcnt < 14)     bcnt <= bcnt + 1;
    else                                 bcnt <= 0;
    busy_i <= (bcnt >= 2 && bcnt < 14);
  end

  // Collector and protocol monitors
  logic [16:0] words[$];
  int   last_cnt = 0, rd_pulses = 0, rdw_err = 0, stall_err = 0, cs0_cyc = 0, gap_err = 0;
  int   low_run = 0;
  logic held_v = 1'b0;
  logic [16:0] held_w;
  logic [1:0]  cs_prev = 2'b11;

  always @(posedge clk) begin
    if (!reset_i && pkt_valid_o && pkt_ready_i) begin
      words.push_back({pkt_last_o, pkt_data_o});
      if (pkt_last_o) last_cnt <= last_cnt + 1;
    end
    if (held_v && (!pkt_valid_o || {pkt_last_o, pkt_data_o} != held_w)) stall_err <= stall_err + 1;
    held_v <= !reset_i && pkt_valid_o && !pkt_ready_i;
    held_w <= {pkt_last_o, pkt_data_o};
    if (!rd_o) begin
      low_run <= low_run + 1;
    end else if (low_run != 0) begin
      rd_pulses <= rd_pulses + 1;
      if (low_run != 2) rdw_err <= rdw_err + 1;
      low_run <= 0;
    end
    if (!cs_o[0]) cs0_cyc <= cs0_cyc + 1;
    if (cs_prev != 2'b11 && cs_o != 2'b11 && cs_o != cs_prev) gap_err <= gap_err + 1;
    cs_prev <= cs_o;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]       mask;
    logic [15:0]      base;
    logic             toggle;
    logic [3:0]       len;
    logic [3:0]       rds;
    logic [0:6][15:0] w;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] m, input logic [15:0] b, input logic t,
                              input logic [3:0] len, input logic [3:0] rds,
                              input logic [0:6][15:0] w);
    vec_t v;
    v.mask = m;
    v.base = b;
    v.toggle = t;
    v.len = len;
    v.rds = rds;
    v.w = w;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int q0, r0, w0, s0, c0, g0, l0, n, got;
    adc_mask_i = v.mask;
    base       = v.base;
    ready_lvl  = 1'b1;
    ready_mode = v.toggle;
    q0 = words.size(); r0 = rd_pulses; w0 = rdw_err; s0 = stall_err;
    c0 = cs0_cyc; g0 = gap_err; l0 = last_cnt;
    period_i = 16'd200;
    en_i = 1'b1;
    n = 0;
    while (!active_o && n < 400) begin @(negedge clk); n++; end
    check($sformatf("%s start", tag), {31'b0, active_o}, 32'd1);
    en_i = 1'b0;
    n = 0;
    while (last_cnt == l0 && n < 2000) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    check($sformatf("%s done", tag), 32'(last_cnt - l0), 32'd1);
    got = words.size() - q0;
    check($sformatf("%s len", tag), 32'(got), 32'(v.len));
    for (int i = 0; i < int'(v.len); i++) begin
      if (i < got)
        check($sformatf("%s word%0d", tag, i), {15'b0, words[q0 + i]},
              {15'b0, (i == int'(v.len) - 1), v.w[i]});
    end
    check($sformatf("%s rd_pulses", tag), 32'(rd_pulses - r0), 32'(v.rds));
    check($sformatf("%s rd_low_width", tag), 32'(rdw_err - w0), 32'd0);
    check($sformatf("%s stall_hold", tag), 32'(stall_err - s0), 32'd0);
    check($sformatf("%s cs_gap", tag), 32'(gap_err - g0), 32'd0);
    check($sformatf("%s cs0_used", tag), {31'b0, (cs0_cyc != c0)}, {31'b0, v.mask[0]});
    ready_mode = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " conv"}, {31'b0, conv_o}, 32'd1);
    check({tag, " cs"}, {30'b0, cs_o}, 32'd3);
    check({tag, " rd"}, {31'b0, rd_o}, 32'd1);
    check({tag, " valid"}, {31'b0, pkt_valid_o}, 32'd0);
    check({tag, " last"}, {31'b0, pkt_last_o}, 32'd0);
    check({tag, " data"}, {16'b0, pkt_data_o}, 32'd0);
    check({tag, " overrun"}, {24'b0, overrun_cnt_o}, 32'd0);
    check({tag, " timeout"}, {31'b0, timeout_err_o}, 32'd0);
    check({tag, " active"}, {31'b0, active_o}, 32'd0);
  endtask

  vec_t vecs[6];
  vec_t v_after_tmo, v_after_rst;

  initial begin
    int n, q0;
    vecs[0] = mk(2'b11, 16'h0000, 1'b0, 4'd7, 4'd4,
                 {16'hAAAA, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h000A});
    vecs[1] = mk(2'b11, 16'h0000, 1'b0, 4'd7, 4'd4,
                 {16'hAAAA, 16'h0001, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h000B});
    vecs[2] = mk(2'b10, 16'h0100, 1'b0, 4'd5, 4'd2,
                 {16'hAAAA, 16'h0002, 16'h0103, 16'h0104, 16'h0209, 16'h0, 16'h0});
    vecs[3] = mk(2'b00, 16'h0000, 1'b0, 4'd3, 4'd0,
                 {16'hAAAA, 16'h0003, 16'h0003, 16'h0, 16'h0, 16'h0, 16'h0});
    vecs[4] = mk(2'b01, 16'h0010, 1'b1, 4'd5, 4'd2,
                 {16'hAAAA, 16'h0004, 16'h0011, 16'h0012, 16'h0027, 16'h0, 16'h0});
    vecs[5] = mk(2'b11, 16'hFFF0, 1'b1, 4'd7, 4'd4,
                 {16'hAAAA, 16'h0005, 16'hFFF1, 16'hFFF2, 16'hFFF3, 16'hFFF4, 16'hFFCF});
    v_after_tmo = mk(2'b11, 16'h0000, 1'b0, 4'd7, 4'd4,
                 {16'hAAAA, 16'h0006, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0010});
    v_after_rst = mk(2'b11, 16'h0020, 1'b0, 4'd7, 4'd4,
                 {16'hAAAA, 16'h0000, 16'h0021, 16'h0022, 16'h0023, 16'h0024, 16'h008A});

    reset_i = 1'b1;
    en_i = 1'b0;
    period_i = 16'd0;
    adc_mask_i = 2'b00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_i = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // BUSY never rises: timeout, no words, sequence untouched
    busy_en = 1'b0;
    adc_mask_i = 2'b11;
    q0 = words.size();
    period_i = 16'd200;
    en_i = 1'b1;
    n = 0;
    while (!active_o && n < 400) begin @(negedge clk); n++; end
    en_i = 1'b0;
    n = 0;
    while (active_o && n < 6000) begin @(negedge clk); n++; end
    check("tmo idle", {31'b0, active_o}, 32'd0);
    check("tmo flag", {31'b0, timeout_err_o}, 32'd1);
    check("tmo duration", {31'b0, (n >= 4096)}, 32'd1);
    check("tmo no words", 32'(words.size() - q0), 32'd0);
    busy_en = 1'b1;
    run_vec(v_after_tmo, "post_tmo");
    check("tmo sticky", {31'b0, timeout_err_o}, 32'd1);

    // Downstream blocked: triggers at cycles 20,40,60,80,100 -> first accepted, 4 dropped
    ready_lvl = 1'b0;
    adc_mask_i = 2'b11;
    @(negedge clk);
    period_i = 16'd20;
    en_i = 1'b1;
    repeat (110) @(negedge clk);
    check("overrun count", {24'b0, overrun_cnt_o}, 32'd4);
    period_i = 16'd1;
    repeat (300) @(negedge clk);
    check("overrun saturate", {24'b0, overrun_cnt_o}, 32'd255);
    en_i = 1'b0;
    ready_lvl = 1'b1;
    n = 0;
    while (active_o && n < 400) begin @(negedge clk); n++; end
    check("drain idle", {31'b0, active_o}, 32'd0);

    // Reset in the middle of a read phase
    period_i = 16'd200;
    en_i = 1'b1;
    n = 0;
    while (rd_o && n < 800) begin @(negedge clk); n++; end
    check("mid rd reached", {31'b0, rd_o}, 32'd0);
    en_i = 1'b0;
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    reset_i = 1'b0;
    repeat (3) @(negedge clk);
    run_vec(v_after_rst, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
